serial_adder_ctrl: RTL and testbench

- Sequences a single 1-bit add cell to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- The add cell is two half_adder instances plus an OR of their carries. Equivalent inline logic is acceptable.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- One operation in flight at a time.

---
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-add cell stepped LSB first, one bit per clock.
// Latency WIDTH clocks from accept to result; one operation in flight, result held until out_ready.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;

    // Full-add cell built from two half adders plus an OR of their carries.
    logic ha1_s, ha1_c, ha2_c, bit_s, bit_c;
    assign ha1_s = sa[0] ^ sb[0];
    assign ha1_c = sa[0] & sb[0];
    assign bit_s = ha1_s ^ carry;
    assign ha2_c = ha1_s & carry;
    assign bit_c = ha1_c | ha2_c;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sa    <= a;
                sb    <= b;
                acc   <= '0;
                carry <= 1'b0;
                cnt   <= '0;
            end
            if (state == RUN) begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                acc   <= {bit_s, acc[WIDTH-1:1]};
                carry <= bit_c;
                cnt   <= cnt + 1'b1;
                // Final bit: publish the assembled word directly, bypassing acc.
                if (cnt == LAST) begin
                    sum       <= {bit_s, acc[WIDTH-1:1]};
                    carry_out <= bit_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected sums queued at accept, compared at hand-off.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH:0] sb_q[$];
    logic [WIDTH:0] sb_exp;
    logic [WIDTH:0] last_res;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hand-off happens on the edge after a negedge that sees out_valid && out_ready.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("result", {23'd0, carry_out, sum}, {23'd0, sb_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair until accepted; returns one step after the accept edge.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                sb_q.push_back({1'b0, av} + {1'b0, bv});
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Full operation: accept, latency/busy/hold checks, optional stall and mid-RUN pulse, hand-off.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input int stall, input int pulse_at);
        bit             ok;
        int             lat;
        logic [WIDTH:0] exp;
        exp = {1'b0, av} + {1'b0, bv};
        send(av, bv, ok);
        if (!ok) return;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            if (pulse_at != 0 && i == pulse_at) begin
                in_valid = 1'b1;
                a        = 8'h11;
                b        = 8'h22;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
            check("sum_hold_run", {23'd0, carry_out, sum}, {23'd0, last_res});
        end
        in_valid = 1'b0;
        if (lat == 0) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", lat, WIDTH);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", {23'd0, carry_out, sum}, {23'd0, exp});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after_handoff", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
        check("busy_after_handoff", {31'd0, busy}, 32'd0);
        check("sum_hold_idle", {23'd0, carry_out, sum}, {23'd0, exp});
        last_res = exp;
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        last_res  = '0;

        repeat (3) tick();
        check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(8'hFF, 8'h01, 0, 0);
        run_op(8'h5A, 8'h25, 0, 0);
        run_op(8'h80, 8'h80, 0, 0);
        run_op(8'hC3, 8'h7E, 5, 0);
        run_op(8'h03, 8'h04, 0, 3);
        for (int i = 0; i < 12; i++) begin
            out_ready = 1'b1;
            tick();
            check("no_second_result", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;

        // Abort on the 4th RUN cycle; the partial result must never appear.
        send(8'hF0, 8'h0F, ok);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sum", {23'd0, carry_out, sum}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        last_res  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        run_op(8'h01, 8'h01, 0, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                   $urandom_range(0, 3), 0);
        end
        run_op(8'hFF, 8'hFF, 1, 0);

        tick();
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
